sc_sng_bank: RTL and testbench
==============================

# sc_sng_bank

Stochastic number generator bank: converts N unsigned W-bit binary values into N parallel unipolar bitstreams of one frame (2^W−1 cycles) each. Sits directly upstream of the cascading-AND multiplier. STREAM drives its input vector and STREAM_VALID drives its enable, so the AND output is the stochastic product of the loaded values. Each channel uses an independently seeded LFSR, so streams are decorrelated and the AND computes a true product.

## Interface
- N, 3, number of channels (≥2; matches multiplier input count)
- W, 8, value/LFSR width (4..16)
- SEED_STRIDE, 37, per-channel seed offset (must be coprime with 2^W−1)
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- LOAD_VALID  in  1  VALUES holds a new operand set
- LOAD_READY  out  1  block can accept a set this cycle
- VALUES  in  N*W  channel k at bits [k*W +: W], unsigned
- ABORT  in  1  synchronous; terminate current frame and flush pending set
- STREAM  out  N  stochastic bits, one per channel
- STREAM_VALID  out  1  STREAM is part of an active frame
- FRAME_START  out  1  first cycle of a frame
- FRAME_LAST  out  1  last cycle of a frame

## Operation
- Handshake: a set transfers on a rising edge with LOAD_VALID & LOAD_READY.
- LOAD_READY = !pending_full. It is combinational from registered state, with no dependence on LOAD_VALID.
- States:
  - IDLE: no frame active.
  - RUN: frame active. Holds the active value register, the pending register plus pending_full, and the frame counter fcnt (0..2^W−2).
- IDLE → RUN on a transfer. Values go straight to the active register, LFSRs load their seeds, and fcnt = 0.
- RUN, fcnt < 2^W−2: fcnt increments and all LFSRs step. A transfer in this state fills pending.
- RUN, fcnt = 2^W−2 (FRAME_LAST cycle), next-frame selection:
  - pending_full: pending becomes active and pending_full clears.
  - else if a transfer occurs this cycle: incoming VALUES becomes active (bypass).
  - else: go to IDLE.
  - For a new frame, LFSRs reload their seeds and fcnt = 0. There is no gap cycle between frames.
- Per-channel LFSR: Fibonacci, maximal length, nonzero states 1..2^W−1. Taps come from the package table.
- Seed for channel k = ((k*SEED_STRIDE) mod (2^W−1)) + 1. This is never zero, and channels are distinct when N < 2^W−1.
- Comparator: STREAM[k] = (lfsr_k ≤ value_k).
  - Each frame contains exactly value_k ones.
  - value 0 gives an all-zero stream; value 2^W−1 gives an all-ones stream.
- ABORT has priority over everything. Next state is IDLE, pending_full clears, and any transfer in the same cycle is discarded, even if LOAD_READY was high.
- Outputs when not in RUN: STREAM = 0, STREAM_VALID = 0, FRAME_START = 0, FRAME_LAST = 0.

## Timing
- Reset values: IDLE, STREAM = 0, STREAM_VALID = 0, FRAME_START = 0, FRAME_LAST = 0, LOAD_READY = 1, pending_full = 0, LFSRs at seed.
- Reset asserted mid-frame takes effect immediately. The partial frame is lost.
- Latency: transfer at edge e gives FRAME_START = 1 and the first STREAM bit in the cycle after e.
- All stream outputs are registered, or derived only from registered state.
- Frame duration is exactly 2^W−1 cycles of STREAM_VALID = 1.
- FRAME_START and FRAME_LAST are one-cycle pulses. They are both high in the same cycle only if W were 1, which is not allowed.
- Back-to-back frames: FRAME_LAST of frame i is immediately followed by FRAME_START of frame i+1. STREAM_VALID stays high throughout.
- Once pending_full sets, LOAD_READY is low from the next cycle and stays low until the frame boundary consumes the pending set.

## Structure
- Shared package sc_pkg holds:
  - function lfsr_taps(W) returning the maximal-length tap mask for 4..16;
  - function sng_seed(k, W, stride);
  - state enum {SNG_IDLE, SNG_RUN}.
- Sub-module sc_lfsr (parameter W, SEED), ports: CLK, RESET_N, LOAD_SEED, STEP, Q[W-1:0]. Instantiate it N times via generate.
- The comparator and frame FSM live in sc_sng_bank.

## Test plan
- N=3, W=4, VALUES={15,15,15}, single transfer → exactly 15 cycles of STREAM = 3'b111, FRAME_START in cycle 1, FRAME_LAST in cycle 15, then IDLE with all outputs 0.
- VALUES={5,0,10} → per-frame ones counts 5, 0, 10 on channels 0, 1, 2; an AND of channels 0 and 2 yields 1..5 ones (checked against the reference model).
- Transfer set A, then set B during cycle 3 of A's frame → LOAD_READY low from cycle 4, B's FRAME_START in the cycle after A's FRAME_LAST, STREAM_VALID continuous for 30 cycles.
- No pending set, transfer asserted in the FRAME_LAST cycle → bypass: the next frame starts with no gap, using the new values.
- ABORT at cycle 7 with a pending set and LOAD_VALID high → next cycle IDLE, outputs 0, LOAD_READY = 1, no frame starts.
- RESET_N pulsed low mid-frame, asynchronously between edges → outputs 0 immediately. A new transfer after release reproduces exactly the same bit sequence as a fresh run, confirming LFSRs restart from their seeds.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing blocks: LFSR tap table,
// per-channel seed derivation and the SNG frame state encoding.
package sc_pkg;

  typedef enum logic {SNG_IDLE, SNG_RUN} sng_state_t;

  // Maximal-length Fibonacci tap masks (bit i = stage i+1) for shift-left, feedback into bit 0
  function automatic logic [15:0] lfsr_taps(input int unsigned w);
    logic [15:0] taps;
    case (w)
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = '0;
    endcase
    return taps;
  endfunction

  function automatic logic [15:0] sng_seed(input int unsigned k, input int unsigned w,
                                           input int unsigned stride);
    int unsigned period;
    period = (32'd1 << w) - 32'd1;
    return 16'((k * stride) % period + 32'd1);
  endfunction

endpackage

// File: rtl/sc_sng_bank_if.sv
// Operand-load handshake and stream outputs of the SNG bank.
interface sc_sng_bank_if #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 8
);
  logic           LOAD_VALID;
  logic           LOAD_READY;
  logic [N*W-1:0] VALUES;
  logic           ABORT;
  logic [N-1:0]   STREAM;
  logic           STREAM_VALID;
  logic           FRAME_START;
  logic           FRAME_LAST;

  modport master (
    output LOAD_VALID, VALUES, ABORT,
    input  LOAD_READY, STREAM, STREAM_VALID, FRAME_START, FRAME_LAST
  );

  modport slave (
    input  LOAD_VALID, VALUES, ABORT,
    output LOAD_READY, STREAM, STREAM_VALID, FRAME_START, FRAME_LAST
  );
endinterface

// File: rtl/sc_lfsr.sv
// Fibonacci maximal-length LFSR with seed reload; steps only when STEP is high.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int unsigned   W    = 8,
  parameter logic [W-1:0]  SEED = 1
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         LOAD_SEED,
  input  logic         STEP,
  output logic [W-1:0] Q
);

  localparam logic [15:0] TAPS16 = lfsr_taps(W);
  localparam logic [W-1:0] TAPS  = TAPS16[W-1:0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)       Q <= SEED;
    else if (LOAD_SEED) Q <= SEED;
    else if (STEP)      Q <= {Q[W-2:0], ^(Q & TAPS)};
  end

endmodule

// File: rtl/sc_sng_bank.sv
// Bank of N LFSR-based stochastic number generators producing one
// 2^W-1 cycle unipolar frame per loaded operand set, with one pending slot.
module sc_sng_bank
  import sc_pkg::*;
#(
  parameter int unsigned N           = 3,
  parameter int unsigned W           = 8,
  parameter int unsigned SEED_STRIDE = 37
) (
  input  logic        CLK,
  input  logic        RESET_N,
  sc_sng_bank_if.slave bus
);

  localparam logic [W-1:0] FCNT_LAST = {{(W-1){1'b1}}, 1'b0};

  sng_state_t     state, state_next;
  logic [W-1:0]   fcnt;
  logic [N*W-1:0] active, pending;
  logic           pending_full;
  logic           xfer, at_last, start_frame, lfsr_step;
  logic [W-1:0]   lfsr_q [N];
  logic [N-1:0]   stream_bits;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= SNG_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    xfer        = bus.LOAD_VALID & !pending_full;
    at_last     = (state == SNG_RUN) && (fcnt == FCNT_LAST);
    start_frame = 1'b0;
    state_next  = state;
    if (bus.ABORT) begin
      state_next = SNG_IDLE;
    end else begin
      case (state)
        SNG_IDLE: if (xfer) begin
          state_next  = SNG_RUN;
          start_frame = 1'b1;
        end
        SNG_RUN: if (at_last) begin
          if (pending_full || xfer) start_frame = 1'b1;
          else                      state_next  = SNG_IDLE;
        end
        default: state_next = SNG_IDLE;
      endcase
    end
    lfsr_step = (state == SNG_RUN) && !at_last;
  end

  // On the last cycle a full pending slot wins over a same-cycle bypass transfer
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fcnt         <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (bus.ABORT) begin
      pending_full <= 1'b0;
    end else begin
      if (start_frame) begin
        fcnt   <= '0;
        active <= (at_last && pending_full) ? pending : bus.VALUES;
      end else if (state == SNG_RUN) begin
        fcnt <= fcnt + 1'b1;
      end
      if (at_last && pending_full) begin
        pending_full <= 1'b0;
      end else if (state == SNG_RUN && !at_last && xfer) begin
        pending      <= bus.VALUES;
        pending_full <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam logic [15:0] SEED16 = sng_seed(unsigned'(k), W, SEED_STRIDE);
    sc_lfsr #(.W(W), .SEED(SEED16[W-1:0])) u_lfsr (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .LOAD_SEED (start_frame),
      .STEP      (lfsr_step),
      .Q         (lfsr_q[k])
    );
  end

  always_comb begin
    stream_bits = '0;
    for (int unsigned k = 0; k < N; k++)
      stream_bits[k] = (state == SNG_RUN) && (lfsr_q[k] <= active[k*W +: W]);
    bus.STREAM       = stream_bits;
    bus.STREAM_VALID = (state == SNG_RUN);
    bus.FRAME_START  = (state == SNG_RUN) && (fcnt == '0);
    bus.FRAME_LAST   = at_last;
    bus.LOAD_READY   = !pending_full;
  end

endmodule

// File: tb/tb_sc_sng_bank.sv
// Scoreboard bench for sc_sng_bank (N=3, W=4): stimulus pushes expected
// per-cycle stream words, a negedge monitor pops and compares them.
module tb_sc_sng_bank;

  logic CLK;
  logic RESET_N;

  sc_sng_bank_if #(.N(3), .W(4)) bus ();

  sc_sng_bank #(.N(3), .W(4), .SEED_STRIDE(37)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  stream;
    logic        start;
    logic        last;
    logic [11:0] vals;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Hand-stepped LFSR states per frame cycle; seeds 1, 8, 15 for channels 0..2
  logic [3:0] seq [3][15] = '{
    '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10, 4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8},
    '{4'd8, 4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10, 4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12},
    '{4'd15, 4'd14, 4'd12, 4'd8, 4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10, 4'd5, 4'd11, 4'd7}
  };

  // Hand-derived frame for {5,0,10}; channel 0 AND channel 2 has 2 ones
  logic [2:0] frame_5_0_10 [15] = '{
    3'b001, 3'b001, 3'b001, 3'b100, 3'b101, 3'b100, 3'b100, 3'b100,
    3'b101, 3'b100, 3'b000, 3'b100, 3'b100, 3'b000, 3'b100
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] vals3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {c, b, a};
  endfunction

  task automatic push_frame(input logic [11:0] v);
    exp_t e;
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < 3; k++) e.stream[k] = (seq[k][i] <= v[k*4 +: 4]);
      e.start = (i == 0);
      e.last  = (i == 14);
      e.vals  = v;
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the accepting edge
  task automatic xfer(input logic [11:0] v);
    logic ok;
    ok = 1'b0;
    bus.LOAD_VALID = 1'b1;
    bus.VALUES     = v;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (bus.LOAD_READY) ok = 1'b1;
      @(posedge CLK);
      #1;
    end
    bus.LOAD_VALID = 1'b0;
    if (ok) push_frame(v);
    else    check("xfer_timeout", 32'd0, 32'd1);
  endtask

  // Monitor
  initial begin
    exp_t e;
    int ones [3];
    forever begin
      @(negedge CLK);
      if (bus.STREAM_VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream", {29'd0, bus.STREAM}, {29'd0, e.stream});
          check("frame_start", {31'd0, bus.FRAME_START}, {31'd0, e.start});
          check("frame_last", {31'd0, bus.FRAME_LAST}, {31'd0, e.last});
          if (e.start) for (int k = 0; k < 3; k++) ones[k] = 0;
          for (int k = 0; k < 3; k++) ones[k] += int'(bus.STREAM[k]);
          if (e.last)
            for (int k = 0; k < 3; k++)
              check("ones_count", ones[k], {28'd0, e.vals[k*4 +: 4]});
        end
      end else begin
        check("idle_outputs", {26'd0, bus.STREAM, bus.STREAM_VALID, bus.FRAME_START, bus.FRAME_LAST}, 32'd0);
      end
    end
  end

  initial begin
    logic [11:0] v;
    logic        all_valid;
    RESET_N        = 1'b0;
    bus.LOAD_VALID = 1'b0;
    bus.VALUES     = '0;
    bus.ABORT      = 1'b0;
    @(posedge CLK); #2;
    check("reset_ready", {31'd0, bus.LOAD_READY}, 32'd1);
    check("reset_outputs", {26'd0, bus.STREAM, bus.STREAM_VALID, bus.FRAME_START, bus.FRAME_LAST}, 32'd0);
    @(posedge CLK); #3;
    RESET_N = 1'b1;
    cyc(1);

    // Full-scale values: 15 cycles of all ones
    xfer(vals3(4'd15, 4'd15, 4'd15));
    cyc(17);

    // Mixed values, cross-checked against the hand-derived frame
    xfer(vals3(4'd5, 4'd0, 4'd10));
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      check("frame_5_0_10", {29'd0, bus.STREAM}, {29'd0, frame_5_0_10[i]});
      @(posedge CLK); #1;
    end
    cyc(2);

    // Pending set loaded in cycle 3 of the running frame
    xfer(vals3(4'd3, 4'd7, 4'd12));
    cyc(2);
    xfer(vals3(4'd15, 4'd1, 4'd8));
    all_valid = 1'b1;
    for (int c = 4; c <= 30; c++) begin
      @(negedge CLK);
      if (c == 4)  check("ready_low_after_pending", {31'd0, bus.LOAD_READY}, 32'd0);
      if (c == 15) check("ready_low_at_last", {31'd0, bus.LOAD_READY}, 32'd0);
      if (c == 16) check("ready_high_next_frame", {31'd0, bus.LOAD_READY}, 32'd1);
      if (bus.STREAM_VALID !== 1'b1) all_valid = 1'b0;
      @(posedge CLK); #1;
    end
    check("continuous_valid", {31'd0, all_valid}, 32'd1);
    cyc(2);

    // Bypass: transfer lands exactly in the FRAME_LAST cycle
    xfer(vals3(4'd1, 4'd14, 4'd6));
    cyc(14);
    xfer(vals3(4'd9, 4'd4, 4'd2));
    @(negedge CLK);
    check("bypass_start", {31'd0, bus.FRAME_START}, 32'd1);
    check("bypass_ready", {31'd0, bus.LOAD_READY}, 32'd1);
    @(posedge CLK); #1;
    cyc(16);

    // ABORT at cycle 7 with a pending set and LOAD_VALID high
    xfer(vals3(4'd4, 4'd11, 4'd13));
    cyc(1);
    xfer(vals3(4'd2, 4'd2, 4'd2));
    cyc(4);
    bus.ABORT      = 1'b1;
    bus.LOAD_VALID = 1'b1;
    bus.VALUES     = vals3(4'd7, 4'd7, 4'd7);
    @(posedge CLK); #1;
    bus.ABORT      = 1'b0;
    bus.LOAD_VALID = 1'b0;
    exp_q.delete();
    check("abort_valid", {31'd0, bus.STREAM_VALID}, 32'd0);
    check("abort_stream", {29'd0, bus.STREAM}, 32'd0);
    check("abort_ready", {31'd0, bus.LOAD_READY}, 32'd1);
    cyc(20);

    // ABORT while idle discards a transfer that LOAD_READY would accept
    bus.ABORT      = 1'b1;
    bus.LOAD_VALID = 1'b1;
    bus.VALUES     = vals3(4'd8, 4'd8, 4'd8);
    @(posedge CLK); #1;
    bus.ABORT      = 1'b0;
    bus.LOAD_VALID = 1'b0;
    check("abort_idle_no_frame", {31'd0, bus.STREAM_VALID}, 32'd0);
    cyc(5);

    // Asynchronous reset mid-frame, then a fresh run must replay the seeded sequence
    v = vals3(4'd5, 4'd0, 4'd10);
    xfer(v);
    cyc(5);
    #1 RESET_N = 1'b0;
    #1;
    check("async_reset_outputs", {26'd0, bus.STREAM, bus.STREAM_VALID, bus.FRAME_START, bus.FRAME_LAST}, 32'd0);
    check("async_reset_ready", {31'd0, bus.LOAD_READY}, 32'd1);
    exp_q.delete();
    @(posedge CLK); @(posedge CLK); #3;
    RESET_N = 1'b1;
    cyc(1);
    xfer(v);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
